mips_boot_ctrl: RTL and testbench

Run controller for the single-cycle MIPS core. It holds the core in reset while a program is streamed into instruction memory over a valid/ready port, then releases the core and runs it until a halt word is fetched or a cycle budget expires. Finally it freezes the core so register-file and data-memory state can be inspected. It sits between the bench or host and the `MIPS` top, driving instruction-memory writes and the core's reset and stall inputs.

---
 rtl/mips_boot_ctrl.sv | 142 ++++++++++++++
 tb/tb_mips_boot_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_boot_ctrl.sv
// Run controller for the single-cycle MIPS core: streams a program into
// instruction memory with the core held in reset, releases and runs the core
// until a halt word or cycle budget, then freezes it for inspection.
module mips_boot_ctrl #(
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0]  HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic [CNT_WIDTH-1:0]  run_cycles,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  input  logic [DATA_WIDTH-1:0] core_instr,
  output logic                  core_rst_n,
  output logic                  core_stall,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [LW-1:0]          r_len;
  logic [LW-1:0]          r_ptr;
  logic [CNT_WIDTH-1:0]   r_budget;
  logic [CNT_WIDTH-1:0]   r_cycle;
  logic                   r_timeout;
  logic                   r_done;
  logic                   r_busy;

  logic [LW-1:0]          w_len;
  logic                   w_hs;
  logic                   w_last;
  logic                   w_halt;
  logic                   w_budget_hit;
  logic                   w_start;

  // Clamp so the write pointer can never wrap past the top of memory.
  assign w_len        = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  assign w_hs         = (r_state == S_LOAD) && s_valid;
  assign w_last       = (r_ptr == (r_len - LW'(1)));
  assign w_halt       = (core_instr == HALT_WORD);
  assign w_budget_hit = (r_budget != '0) && (r_cycle == (r_budget - CNT_WIDTH'(1)));

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    s_ready    = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    core_rst_n = 1'b0;
    core_stall = 1'b1;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) core_rst_n = 1'b1;
        if (start) begin
          w_start = 1'b1;
          w_next  = (w_len != '0) ? S_LOAD : S_RELEASE;
        end
      end
      S_LOAD: begin
        s_ready    = 1'b1;
        imem_we    = w_hs;
        imem_addr  = r_ptr[ADDR_WIDTH-1:0];
        imem_wdata = s_data;
        if (w_hs && w_last) w_next = S_RELEASE;
      end
      S_RELEASE: w_next = S_RUN;
      S_RUN: begin
        core_rst_n = 1'b1;
        core_stall = 1'b0;
        if (w_halt || w_budget_hit) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides start and every RUN exit.
    if (abort) begin
      w_next  = S_IDLE;
      w_start = 1'b0;
    end
  end

  // State register plus session datapath (pointer, counter, flags).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_ptr     <= '0;
      r_budget  <= '0;
      r_cycle   <= '0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_LOAD) || (w_next == S_RELEASE) || (w_next == S_RUN);
      r_done  <= (w_next == S_DONE) && (r_state != S_DONE);
      if (w_start) begin
        r_len     <= w_len;
        r_budget  <= run_cycles;
        r_ptr     <= '0;
        r_cycle   <= '0;
        r_timeout <= 1'b0;
      end else begin
        if (w_hs) r_ptr <= r_ptr + LW'(1);
        if ((r_state == S_RUN) && !abort) begin
          if (r_cycle != '1) r_cycle <= r_cycle + CNT_WIDTH'(1);
          if (w_next == S_DONE) r_timeout <= !w_halt;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Directed bench for mips_boot_ctrl: load/halt, timeout, backpressure,
// abort, skip-load with unlimited budget, length clamp and async reset.
module tb_mips_boot_ctrl;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [8:0]  load_len;
  logic [15:0] run_cycles;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] core_instr;
  logic        core_rst_n;
  logic        core_stall;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  mips_boot_ctrl #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .CNT_WIDTH (16),
    .HALT_WORD (HALT)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .abort      (abort),
    .load_len   (load_len),
    .run_cycles (run_cycles),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_instr (core_instr),
    .core_rst_n (core_rst_n),
    .core_stall (core_stall),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; load_len = '0; run_cycles = '0;
    s_valid = 1'b1; s_data = 32'h1234_5678; core_instr = '0;

    // Reset values
    mid();
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_core_stall", core_stall, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cycle_count", cycle_count, 0);
    adv();
    rst_n = 1'b1; s_valid = 1'b0;
    adv();

    // Load 3 words then halt on RUN cycle 4
    start = 1'b1; load_len = 9'd3; run_cycles = 16'd10; s_valid = 1'b1; s_data = 32'hAAAA_0001;
    adv();
    start = 1'b0;
    mid();
    chk("ld_s_ready", s_ready, 1);
    chk("ld_we0", imem_we, 1);
    chk("ld_addr0", imem_addr, 0);
    chk("ld_data0", imem_wdata, 32'hAAAA_0001);
    chk("ld_busy", busy, 1);
    chk("ld_core_rst_n", core_rst_n, 0);
    adv();
    s_data = 32'hBBBB_0002;
    mid();
    chk("ld_addr1", imem_addr, 1);
    chk("ld_data1", imem_wdata, 32'hBBBB_0002);
    adv();
    s_data = 32'hCCCC_0003;
    mid();
    chk("ld_we2", imem_we, 1);
    chk("ld_addr2", imem_addr, 2);
    chk("ld_data2", imem_wdata, 32'hCCCC_0003);
    adv();
    mid();
    chk("rel_s_ready", s_ready, 0);
    chk("rel_we", imem_we, 0);
    chk("rel_core_rst_n", core_rst_n, 0);
    chk("rel_busy", busy, 1);
    adv();
    s_valid = 1'b0;
    mid();
    chk("run1_core_rst_n", core_rst_n, 1);
    chk("run1_core_stall", core_stall, 0);
    chk("run1_cycle_count", cycle_count, 0);
    adv();
    adv();
    adv();
    core_instr = HALT;
    mid();
    chk("run4_cycle_count", cycle_count, 3);
    adv();
    core_instr = '0;
    mid();
    chk("halt_done", done, 1);
    chk("halt_cycle_count", cycle_count, 4);
    chk("halt_timeout", timeout, 0);
    chk("halt_core_stall", core_stall, 1);
    chk("halt_core_rst_n", core_rst_n, 1);
    chk("halt_busy", busy, 0);
    adv();
    mid();
    chk("halt_done_pulse", done, 0);
    adv();

    // Timeout after 5 RUN cycles
    start = 1'b1; load_len = 9'd1; run_cycles = 16'd5; s_valid = 1'b1; s_data = 32'hDDDD_0004;
    adv();
    start = 1'b0;
    mid();
    chk("to_we", imem_we, 1);
    chk("to_addr", imem_addr, 0);
    adv();
    s_valid = 1'b0;
    mid();
    chk("to_release_ready", s_ready, 0);
    adv();
    for (int k = 1; k <= 5; k++) begin
      mid();
      chk($sformatf("to_run%0d_stall", k), core_stall, 0);
      chk($sformatf("to_run%0d_count", k), cycle_count, 64'(k - 1));
      adv();
    end
    mid();
    chk("to_done", done, 1);
    chk("to_timeout", timeout, 1);
    chk("to_cycle_count", cycle_count, 5);
    chk("to_stall", core_stall, 1);
    adv();
    mid();
    chk("to_timeout_sticky", timeout, 1);
    adv();

    // Backpressure: valid pattern 0,1,0,0,1 restarting from DONE
    start = 1'b1; load_len = 9'd2; run_cycles = 16'd0; s_valid = 1'b0;
    adv();
    start = 1'b0;
    mid();
    chk("bp_c1_we", imem_we, 0);
    chk("bp_c1_core_rst_n", core_rst_n, 0);
    chk("bp_timeout_clr", timeout, 0);
    chk("bp_count_clr", cycle_count, 0);
    adv();
    s_valid = 1'b1; s_data = 32'hEEEE_0005;
    mid();
    chk("bp_c2_we", imem_we, 1);
    chk("bp_c2_addr", imem_addr, 0);
    adv();
    s_valid = 1'b0;
    mid();
    chk("bp_c3_we", imem_we, 0);
    chk("bp_c3_ready", s_ready, 1);
    adv();
    mid();
    chk("bp_c4_we", imem_we, 0);
    adv();
    s_valid = 1'b1; s_data = 32'hFFFF_0006;
    mid();
    chk("bp_c5_we", imem_we, 1);
    chk("bp_c5_addr", imem_addr, 1);
    adv();
    s_valid = 1'b0;
    mid();
    chk("bp_release_ready", s_ready, 0);
    chk("bp_release_rst_n", core_rst_n, 0);
    adv();
    adv();
    adv();
    adv();
    abort = 1'b1;
    mid();
    chk("bp_run4_count", cycle_count, 3);
    adv();
    abort = 1'b0;
    mid();
    chk("ab_run_busy", busy, 0);
    chk("ab_run_done", done, 0);
    chk("ab_run_rst_n", core_rst_n, 0);
    chk("ab_run_stall", core_stall, 1);
    chk("ab_run_count_hold", cycle_count, 3);
    adv();

    // Start during LOAD ignored; abort on 2nd LOAD cycle
    start = 1'b1; load_len = 9'd4; run_cycles = 16'd0;
    adv();
    s_valid = 1'b1; s_data = 32'h0101_0007;
    mid();
    chk("ab_ld1_addr", imem_addr, 0);
    adv();
    start = 1'b0; abort = 1'b1; s_valid = 1'b0;
    mid();
    chk("ab_ld2_addr", imem_addr, 1);
    chk("ab_ld2_ready", s_ready, 1);
    adv();
    abort = 1'b0;
    mid();
    chk("ab_idle_ready", s_ready, 0);
    chk("ab_idle_done", done, 0);
    chk("ab_idle_busy", busy, 0);
    adv();
    mid();
    chk("ab_idle_done2", done, 0);
    adv();

    // Skip load, unlimited budget, halt on RUN cycle 300
    start = 1'b1; load_len = 9'd0; run_cycles = 16'd0;
    adv();
    start = 1'b0;
    mid();
    chk("sk_release_busy", busy, 1);
    chk("sk_release_ready", s_ready, 0);
    chk("sk_release_rst_n", core_rst_n, 0);
    adv();
    mid();
    chk("sk_run1_rst_n", core_rst_n, 1);
    chk("sk_run1_count", cycle_count, 0);
    for (int i = 1; i < 300; i++) adv();
    core_instr = HALT;
    mid();
    chk("sk_run300_count", cycle_count, 299);
    chk("sk_run300_stall", core_stall, 0);
    adv();
    core_instr = '0;
    mid();
    chk("sk_done", done, 1);
    chk("sk_count", cycle_count, 300);
    chk("sk_timeout", timeout, 0);
    adv();

    // Oversized length clamps to 256 words
    start = 1'b1; load_len = 9'h1FF; run_cycles = 16'd0; s_valid = 1'b1; s_data = 32'h0;
    adv();
    start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      s_data = 32'(i);
      adv();
    end
    s_data = 32'h5555_00FF;
    mid();
    chk("cl_last_addr", imem_addr, 8'hFF);
    chk("cl_last_we", imem_we, 1);
    adv();
    mid();
    chk("cl_release_ready", s_ready, 0);
    chk("cl_release_we", imem_we, 0);
    chk("cl_release_busy", busy, 1);
    adv();
    s_valid = 1'b0;
    adv();
    adv();

    // Asynchronous reset mid-RUN
    mid();
    chk("ar_pre_rst_n", core_rst_n, 1);
    chk("ar_pre_count", cycle_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_core_rst_n", core_rst_n, 0);
    chk("ar_core_stall", core_stall, 1);
    chk("ar_busy", busy, 0);
    chk("ar_count", cycle_count, 0);
    adv();
    rst_n = 1'b1;
    adv();
    adv();
    mid();
    chk("ar_idle_busy", busy, 0);
    chk("ar_idle_ready", s_ready, 0);
    chk("ar_idle_rst_n", core_rst_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
